// File: rtl/filt_cici_mc_if.sv
// Frame handshake bundle for filt_cici_mc: input valid/ready/data and output valid/data.
interface filt_cici_mc_if #(
  parameter int unsigned gp_nr_channels = 2,
  parameter int unsigned gp_inp_width   = 8,
  parameter int unsigned gp_oup_width   = 20
);
  logic                                   i_valid;
  logic                                   o_ready;
  logic [gp_nr_channels*gp_inp_width-1:0] i_data;
  logic                                   o_valid;
  logic [gp_nr_channels*gp_oup_width-1:0] o_data;

  modport slave  (input  i_valid, i_data, output o_ready, o_valid, o_data);
  modport master (output i_valid, i_data, input  o_ready, o_valid, o_data);
endinterface

// File: rtl/filt_cici_mc.sv
// Multi-channel CIC interpolator, run-time rate R = 2^k, single clock with phase sequencing.
// Optional output normalisation to unity DC gain: define FILT_CICI_MC_NORM_EN.
module filt_cici_mc #(
  parameter int unsigned gp_nr_channels   = 2,
  parameter int unsigned gp_order         = 3,
  parameter int unsigned gp_diff_delay    = 1,
  parameter int unsigned gp_max_rate_log2 = 4,
  parameter int unsigned gp_inp_width     = 8,
  parameter int unsigned gp_oup_width     = gp_inp_width + gp_order*(gp_max_rate_log2 + gp_diff_delay - 1)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_an,
  input  logic                                i_ena,
  input  logic [$clog2(gp_max_rate_log2+1)-1:0] i_rate_log2,
  filt_cici_mc_if.slave                       bus
);
  localparam int unsigned LP_CH  = gp_nr_channels;
  localparam int unsigned LP_IW  = gp_inp_width;
  localparam int unsigned LP_OW  = gp_oup_width;
  localparam int unsigned LP_KW  = $clog2(gp_max_rate_log2+1);
  localparam int unsigned LP_PW  = gp_max_rate_log2;
  localparam logic [LP_KW-1:0] LP_KMAX = LP_KW'(gp_max_rate_log2);

  typedef logic signed [LP_OW-1:0] t_acc;
  typedef enum logic {S_IDLE, S_RUN} t_state;

  t_state            r_state, w_state_nxt;
  logic [LP_PW-1:0]  r_p, w_p_nxt;
  logic [LP_KW-1:0]  r_k, w_k_nxt, w_k_in;
  logic              r_ready, w_ready_nxt;
  logic              r_valid;
  logic [LP_CH*LP_OW-1:0] r_odata;
  logic              w_accept, w_last_ph, w_run;

  t_acc r_comb_dly  [LP_CH][gp_order][gp_diff_delay];
  t_acc r_stuff     [LP_CH];
  t_acc r_integ     [LP_CH][gp_order];
  t_acc w_comb_in   [LP_CH][gp_order];
  t_acc w_comb_out  [LP_CH];
  t_acc w_integ_nxt [LP_CH][gp_order];
  t_acc w_last      [LP_CH];

  function automatic logic [LP_PW-1:0] f_pmax(input logic [LP_KW-1:0] k);
    return LP_PW'((32'd1 << k) - 32'd1);
  endfunction

  assign w_accept  = i_ena & bus.i_valid & r_ready;
  assign w_last_ph = (r_p == f_pmax(r_k));
  assign w_run     = i_ena & (r_state == S_RUN);
  assign w_k_in    = ((i_rate_log2 == '0) || (i_rate_log2 > LP_KMAX)) ? LP_KMAX : i_rate_log2;

  // Frame sequencer: idle until a frame lands, then R phases per frame
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_k     <= LP_KMAX;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_k     <= w_k_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_k_nxt     = r_k;
    if (i_ena) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt = S_RUN;
            w_p_nxt     = '0;
            w_k_nxt     = w_k_in;
          end
        end
        S_RUN: begin
          if (w_last_ph) begin
            w_p_nxt = '0;
            if (!w_accept) w_state_nxt = S_IDLE;
          end else begin
            w_p_nxt = r_p + LP_PW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_ready_nxt = (w_state_nxt == S_IDLE) || (w_p_nxt == f_pmax(w_k_nxt));
  end

  // Comb chain at input rate, evaluated on the incoming frame
  always_comb begin
    t_acc w_x;
    w_x = '0;
    for (int c = 0; c < LP_CH; c++) begin
      w_x = t_acc'($signed(bus.i_data[c*LP_IW +: LP_IW]));
      for (int j = 0; j < gp_order; j++) begin
        w_comb_in[c][j] = w_x;
        w_x = w_x - r_comb_dly[c][j][gp_diff_delay-1];
      end
      w_comb_out[c] = w_x;
    end
  end

`ifdef FILT_CICI_MC_NORM_EN
  int unsigned w_shift;
  assign w_shift = gp_order * (32'(r_k) + gp_diff_delay - 1) - 32'(r_k);
`endif

  // Integrator chain at output rate; zero-stuffed input except on phase 0
  always_comb begin
    t_acc w_a;
    w_a = '0;
    for (int c = 0; c < LP_CH; c++) begin
      w_a = (r_p == '0) ? r_stuff[c] : '0;
      for (int j = 0; j < gp_order; j++) begin
        w_a = w_a + r_integ[c][j];
        w_integ_nxt[c][j] = w_a;
      end
`ifdef FILT_CICI_MC_NORM_EN
      if (w_shift != 0) w_a = (w_a + (t_acc'(1) <<< (w_shift - 1))) >>> w_shift;
`endif
      w_last[c] = w_a;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      for (int c = 0; c < LP_CH; c++) begin
        r_stuff[c] <= '0;
        for (int j = 0; j < gp_order; j++) begin
          r_integ[c][j] <= '0;
          for (int d = 0; d < gp_diff_delay; d++) r_comb_dly[c][j][d] <= '0;
        end
      end
    end else begin
      if (w_accept) begin
        for (int c = 0; c < LP_CH; c++) begin
          r_stuff[c] <= w_comb_out[c];
          for (int j = 0; j < gp_order; j++) begin
            r_comb_dly[c][j][0] <= w_comb_in[c][j];
            for (int d = 1; d < gp_diff_delay; d++) r_comb_dly[c][j][d] <= r_comb_dly[c][j][d-1];
          end
        end
      end
      if (w_run) begin
        for (int c = 0; c < LP_CH; c++) begin
          for (int j = 0; j < gp_order; j++) r_integ[c][j] <= w_integ_nxt[c][j];
        end
      end
    end
  end

  // Output frame register; holds while disabled or idle
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_valid <= 1'b0;
      r_odata <= '0;
    end else if (i_ena) begin
      r_valid <= (r_state == S_RUN);
      if (r_state == S_RUN) begin
        for (int c = 0; c < LP_CH; c++) r_odata[c*LP_OW +: LP_OW] <= w_last[c];
      end
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_odata;
endmodule

// File: tb/tb_filt_cici_mc.sv
// Bench for filt_cici_mc: closed-form CIC model (binomial-weighted sums) checked every cycle,
// plus literal impulse/step/count expectations.
module tb_filt_cici_mc;
  localparam int unsigned CH   = 2;
  localparam int unsigned N    = 3;
  localparam int unsigned M    = 1;
  localparam int unsigned KMAX = 4;
  localparam int unsigned IW   = 8;
  localparam int unsigned OW   = IW + N*(KMAX + M - 1);
  localparam int unsigned KW   = $clog2(KMAX+1);
`ifdef FILT_CICI_MC_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  logic          clk, rst_n, ena;
  logic [KW-1:0] rate;

  filt_cici_mc_if #(.gp_nr_channels(CH), .gp_inp_width(IW), .gp_oup_width(OW)) bus ();

  filt_cici_mc #(
    .gp_nr_channels(CH), .gp_order(N), .gp_diff_delay(M),
    .gp_max_rate_log2(KMAX), .gp_inp_width(IW), .gp_oup_width(OW)
  ) dut (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_rate_log2(rate), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- model ----------------
  int     pending = 0;
  int     cur_k = KMAX;
  int     idx = 0;
  int     n_out = 0;
  longint x_q [CH][$];
  longint u_q [CH][$];
  int     k_q [$];
  longint obs_q [CH][$];
  longint exp_d [CH];
  logic   exp_v, exp_r;

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (k < 0 || n < k) return 0;
    for (int i = 1; i <= k; i++) r = r * longint'(n - k + i) / longint'(i);
    return r;
  endfunction

  function automatic longint wrapw(input longint v);
    longint m = longint'(1) << OW;
    longint r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  // Output t = sum over stuffed samples weighted by the N-fold running-sum kernel
  function automatic longint model_out(input int c, input int t);
    longint acc = 0;
    int s;
    for (int j = 0; j <= t; j++) acc += binom(t - j + N - 1, N - 1) * u_q[c][j];
    acc = wrapw(acc);
    s = N * (k_q[t] + M - 1) - k_q[t];
    if (NORM && s > 0) acc = wrapw(acc + (longint'(1) << (s - 1))) >>> s;
    return acc;
  endfunction

  always @(posedge clk) begin : p_cmp
    int pb, kn, rr, nx;
    bit acc, emit;
    longint d, xv;
    emit = 1'b0;
    if (!rst_n) begin
      pending = 0; cur_k = KMAX; idx = 0;
      k_q.delete();
      for (int c = 0; c < CH; c++) begin
        x_q[c].delete(); u_q[c].delete(); exp_d[c] = 0;
      end
      exp_v = 1'b0;
    end else if (ena) begin
      pb  = pending;
      acc = bus.i_valid && (pb <= 1);
      if (pb > 0) begin
        for (int c = 0; c < CH; c++) exp_d[c] = model_out(c, idx);
        exp_v = 1'b1; emit = 1'b1;
        idx++; pending--;
      end else begin
        exp_v = 1'b0;
      end
      if (acc) begin
        if (pb == 0) begin
          kn = (rate == 0 || rate > KW'(KMAX)) ? KMAX : int'(rate);
          cur_k = kn;
        end
        rr = 1 << cur_k;
        for (int c = 0; c < CH; c++) begin
          xv = longint'($signed(bus.i_data[c*IW +: IW]));
          x_q[c].push_back(xv);
          nx = x_q[c].size() - 1;
          d = 0;
          for (int i = 0; i <= N; i++)
            if (nx - i*M >= 0)
              d += ((i % 2) ? -1 : 1) * binom(N, i) * x_q[c][nx - i*M];
          for (int r = 0; r < rr; r++) u_q[c].push_back(r == 0 ? d : 0);
        end
        for (int r = 0; r < rr; r++) k_q.push_back(cur_k);
        pending += rr;
      end
    end
    exp_r = (pending <= 1);
    #1;
    check("valid", longint'(bus.o_valid), longint'(exp_v));
    check("ready", longint'(bus.o_ready), longint'(exp_r));
    for (int c = 0; c < CH; c++)
      check($sformatf("data%0d", c), longint'($signed(bus.o_data[c*OW +: OW])), exp_d[c]);
    if (emit) begin
      n_out++;
      for (int c = 0; c < CH; c++) obs_q[c].push_back(longint'($signed(bus.o_data[c*OW +: OW])));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int a, input int b);
    int n = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = {IW'(b), IW'(a)};
    while (!(bus.o_ready && ena)) begin
      @(negedge clk);
      n++;
      if (n > 64) begin bound_fail("send_ready"); return; end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending != 0 && n < 200) begin @(negedge clk); n++; end
    if (pending != 0) bound_fail("wait_idle");
    @(negedge clk);
  endtask

  task automatic run_impulse(input string tag);
    longint tbl [11];
    if (NORM) tbl = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    else      tbl = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};
    for (int c = 0; c < CH; c++) obs_q[c].delete();
    n_out = 0;
    rate = KW'(2);
    send(1, 0); send(0, 0); send(0, 0); send(0, 0);
    bus.i_valid = 1'b0;
    wait_idle();
    check({tag, "_count"}, longint'(n_out), 16);
    if (obs_q[0].size() >= 11 && obs_q[1].size() >= 11) begin
      for (int i = 0; i < 11; i++) begin
        check($sformatf("%s_l0_%0d", tag, i), obs_q[0][i], tbl[i]);
        check($sformatf("%s_l1_%0d", tag, i), obs_q[1][i], 0);
      end
    end else begin
      bound_fail({tag, "_short"});
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; rate = KW'(2);
    bus.i_valid = 1'b0; bus.i_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", longint'(bus.o_valid), 0);
    check("rst_data",  longint'(bus.o_data), 0);
    check("rst_ready", longint'(bus.o_ready), 1);
    rst_n = 1'b1;

    run_impulse("imp");

    // Step, k=2: lane0 +1, lane1 -1, valid held high
    for (int c = 0; c < CH; c++) obs_q[c].delete();
    rate = KW'(2);
    for (int i = 0; i < 12; i++) send(1, -1);
    bus.i_valid = 1'b0;
    wait_idle();
    if (obs_q[0].size() > 0) begin
      check("step_l0", obs_q[0][obs_q[0].size()-1], NORM ? 1 : 16);
      check("step_l1", obs_q[1][obs_q[1].size()-1], NORM ? -1 : -16);
    end else bound_fail("step_short");

    // Handshake, k=3, continuous valid
    n_out = 0;
    rate = KW'(3);
    send(5, -7); send(100, -128); send(-128, 127); send(-1, 1); send(64, -64);
    bus.i_valid = 1'b0;
    wait_idle();
    check("hs_count", longint'(n_out), 40);

    // Rate change mid-burst only takes effect after idle
    n_out = 0;
    rate = KW'(2);
    send(10, -10);
    rate = KW'(3);
    send(-20, 20);
    bus.i_valid = 1'b0;
    wait_idle();
    check("rc_burst_count", longint'(n_out), 8);
    send(30, 1);
    bus.i_valid = 1'b0;
    wait_idle();
    check("rc_total_count", longint'(n_out), 16);

    // Enable gating mid-burst
    n_out = 0;
    rate = KW'(2);
    send(7, -3);
    bus.i_valid = 1'b0;
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ena_hold_valid%0d", i), longint'(bus.o_valid), 1);
    end
    ena = 1'b1;
    wait_idle();
    check("ena_count", longint'(n_out), 4);

    // Out-of-range rate clamps to the maximum
    n_out = 0;
    rate = KW'(0);
    send(3, -2);
    bus.i_valid = 1'b0;
    wait_idle();
    check("clamp_count", longint'(n_out), 16);

    // Reset at phase 2
    rate = KW'(2);
    send(1, 0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", longint'(bus.o_valid), 0);
    check("mrst_data",  longint'(bus.o_data), 0);
    check("mrst_ready", longint'(bus.o_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_ready_rel", longint'(bus.o_ready), 1);
    run_impulse("imp2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/filt_cici_mc.md
# filt_cici_mc

Multi-channel CIC interpolation filter with a run-time selectable power-of-two rate. It runs on a single clock and uses a valid/ready input handshake. It is the next generation of the team's CIC interpolator. One input frame carries one sample for each of `gp_nr_channels` lanes, and each frame produces R output frames. There is no second clock: input-rate and output-rate sections are sequenced by an internal phase counter. The block sits between the per-channel sample source and the downstream rate-converting or DAC-side datapath.

## Interface
- `gp_nr_channels`, 2: number of parallel, independent channel lanes.
- `gp_order`, 3: N, the number of comb stages, equal to the number of integrator stages.
- `gp_diff_delay`, 1: M, the comb differential delay; legal values are 1 and 2.
- `gp_max_rate_log2`, 4: largest supported log2(R).
- `gp_inp_width`, 8: per-channel input width, signed.
- `gp_oup_width`, `gp_inp_width + gp_order*(gp_max_rate_log2 + gp_diff_delay - 1)`: per-channel output width, signed.
- `i_clk` in 1: clock.
- `i_rst_an` in 1: asynchronous, active-low reset.
- `i_ena` in 1: global clock enable; while low, all state holds.
- `i_rate_log2` in `$clog2(gp_max_rate_log2+1)`: k, where R = 2^k; legal range 1..`gp_max_rate_log2`.
- `i_valid` in 1: input frame valid.
- `o_ready` out 1: block can accept a frame.
- `i_data` in `gp_nr_channels*gp_inp_width`: channel c occupies bits `[(c+1)*gp_inp_width-1 -: gp_inp_width]`.
- `o_valid` out 1: `o_data` holds a new output frame.
- `o_data` out `gp_nr_channels*gp_oup_width`: same per-channel packing as `i_data`.

## Operation
- A frame is accepted on a rising edge where `i_ena & i_valid & o_ready` is true.
- Each lane is sign-extended to `gp_oup_width` before any arithmetic.
- All arithmetic is two's complement, modulo 2^`gp_oup_width`. Wrap-around in the integrators is intended behaviour and is not saturated.
- Comb section:
  - N cascaded stages per lane, each y = x − x[n−M].
  - Delay lines advance only on acceptance.
  - The final comb result is latched into `r_stuff`.
- FSM states:
  - S_IDLE: `o_ready`=1.
  - S_RUN: phase counter p counts 0..R−1.
- Transitions:
  - S_IDLE → S_RUN on acceptance; p←0 and R←2^`i_rate_log2` are latched.
  - In S_RUN, each enabled cycle runs the integrators once and increments p.
  - On the enabled cycle with p=R−1, the FSM returns to S_IDLE unless a new frame is accepted on that edge. If one is, it stays in S_RUN with p←0 (back-to-back operation).
- In S_RUN, `o_ready` = (p==R−1).
- Zero-stuffing: the integrator input is `r_stuff` when p=0 and 0 otherwise.
- Integrator section:
  - N cascaded accumulators per lane, with state registers and a combinational add chain.
  - `o_data` is a registered copy of the last adder output.
- `i_rate_log2` is sampled only on acceptance from S_IDLE. Changes while in S_RUN, including back-to-back acceptance, are ignored until the next S_IDLE.
- An out-of-range `i_rate_log2` (0 or >`gp_max_rate_log2`) is clamped to `gp_max_rate_log2`.
- DC gain is (R·M)^N / R.

## Timing
- Reset values:
  - `o_valid`=0, `o_data`=0, `o_ready`=1.
  - FSM in S_IDLE.
  - All comb, integrator and `r_stuff` registers are 0.
- Latency: acceptance at edge t0 gives the first `o_valid` after edge t0+1, with `i_ena` held high.
- One output frame is produced per enabled cycle, R frames per input frame.
- `o_valid` is high for exactly one cycle per output frame. It holds its value while `i_ena`=0; `o_data` is stable throughout.
- Sustained throughput is 1 input frame per R enabled cycles, with no bubbles when `i_valid` is held high.
- Reset asserted mid-frame aborts immediately. Outputs and state take their reset values; no partial frame is emitted after release.
- If `i_valid` is low at p=R−1, the FSM returns to S_IDLE. `o_valid` deasserts after the last phase.

## Configuration
- Macro: `FILT_CICI_MC_NORM_EN`.
- Defined: each lane output is arithmetically right-shifted by s = N·(k + M − 1) − k, rounded half-up by adding 2^(s−1) before the shift. The result is sign-extended back to `gp_oup_width`, giving unity DC gain.
- Not defined: `o_data` is the raw integrator output (full gain); no rounding logic is synthesised.
- Latency is identical in both builds.

## Test plan
- Impulse: N=3, M=1, k=2. Lane 0 gets a frame of 1 followed by frames of 0; lane 1 is all 0. Lane 0 outputs 1,3,6,10,12,12,10,6,3,1, then 0. Lane 1 stays 0.
- Step: N=3, k=2, constant +1 input, `i_valid` held high. Raw output settles to 16 with `o_valid` high every cycle. With `FILT_CICI_MC_NORM_EN` it settles to 1.
- Handshake: `i_valid` high continuously at k=3. `o_ready` pulses high once every 8 cycles. No frames are dropped, and there is exactly 1 output per cycle.
- Rate change: change `i_rate_log2` from 2 to 3 mid-S_RUN. The current burst keeps R=4 until an idle gap. The next accepted frame after S_IDLE produces 8 outputs.
- Enable gating: `i_ena` is low for 3 cycles in mid-burst. `o_data` and `o_valid` freeze. The burst resumes with the identical sequence, with total output count unchanged.
- Reset mid-frame: assert `i_rst_an`=0 at p=2. Outputs are 0 immediately, and `o_ready`=1 after release. Replaying the impulse test reproduces the impulse output sequence exactly.
